uart_byte_rx: RTL and testbench

UART_BYTE_RX -- requirements
Module: uart_byte_rx

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_byte_rx_sync2.sv | 26 ++
 rtl/uart_byte_rx.sv | 170 +++++++++++++++++
 tb/tb_uart_byte_rx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART byte receiver.
// UART_RX_PARITY_EN adds the PARITY state for an even-parity bit after bit 7.
package uart_pkg;

    localparam int unsigned DATA_BITS            = 8;
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;
`endif

endpackage

// File: rtl/uart_byte_rx_sync2.sv
// Two-flop synchronizer for a single asynchronous bit, with selectable reset value.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver sampling each bit at its midpoint.
// Define UART_RX_PARITY_EN for 8E1 frames with an even-parity check.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] value,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic rxs;

    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] value_q, value_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 busy_q, busy_d;
    logic                 cnt_zero_c;
    logic                 frame_ok_c;

    sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rxs)
    );

    assign cnt_zero_c = (cnt_q == '0);

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;

    // Even parity: data bits plus parity bit must contain an even number of ones.
    assign frame_ok_c = rxs & ~(^{shift_q, par_q});

    always_ff @(posedge clk) begin
        if (rst) par_q <= 1'b0;
        else     par_q <= par_d;
    end
`else
    assign frame_ok_c = rxs;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            value_q <= value_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        value_d = value_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif

        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    cnt_d   = CNT_HALF;
                    state_d = START;
                end
            end
            START: begin
                // Re-check the line at mid start bit to reject glitches.
                if (cnt_zero_c) begin
                    if (!rxs) begin
                        cnt_d   = CNT_BIT;
                        idx_d   = '0;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_zero_c) begin
                    shift_d[idx_q] = rxs;
                    cnt_d          = CNT_BIT;
                    if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_zero_c) begin
                    par_d   = rxs;
                    cnt_d   = CNT_BIT;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            STOP: begin
                // A low stop bit means a break or misframe: wait for the line to recover.
                if (cnt_zero_c) begin
                    if (frame_ok_c) begin
                        value_d = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                    state_d = rxs ? IDLE : WAIT_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WAIT_IDLE: begin
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign value     = value_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Randomized and directed bench for uart_byte_rx at 16 clocks per bit,
// checked against a frame-level model of expected pulses and held value.
module tb_uart_byte_rx;

    localparam int unsigned CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit HAS_PAR = 1'b1;
`else
    localparam bit HAS_PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] value;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned cyc = 0;
    int unsigned start_cyc = 0;
    int unsigned lat = 0;
    int          n_valid = 0;
    int          n_ferr = 0;
    int          exp_valid = 0;
    int          exp_ferr = 0;
    logic [7:0]  exp_value = 8'h00;

    uart_byte_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .value     (value),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Pulse monitor: counts pulses, records latency, and checks exclusivity.
    always @(negedge clk) begin
        if (valid) begin
            n_valid++;
            lat = cyc - start_cyc;
        end
        if (frame_err) n_ferr++;
        if (valid || frame_err) check("valid_ferr_exclusive", 32'(valid & frame_err), 32'd0);
    end

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        idle_cycles(CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_flip);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        if (HAS_PAR) drive_bit((^b) ^ par_flip);
        drive_bit(stop_b);
    endtask

    // Model: a frame is good when its stop bit is high and (if enabled) parity is even.
    task automatic expect_frame(input logic [7:0] b, input logic stop_b, input logic par_flip);
        logic good;
        good = stop_b && !(HAS_PAR && par_flip);
        send_frame(b, stop_b, par_flip);
        if (good) begin
            exp_valid++;
            exp_value = b;
        end else begin
            exp_ferr++;
        end
        check("valid_count", 32'(n_valid), 32'(exp_valid));
        check("ferr_count", 32'(n_ferr), 32'(exp_ferr));
        check("value", 32'(value), 32'(exp_value));
        check("busy_after_frame", 32'(busy), 32'(!stop_b));
        if (good) check("latency_in_window", 32'(lat >= 9 * CPB + CPB / 2 + 2 && lat <= 9 * CPB + CPB / 2 + 4), 32'd1);
    endtask

    initial begin
        logic [7:0] b;
        logic       stop_b;
        logic       flip;
        int         gap;

        rst = 1'b1;
        rx  = 1'b1;
        idle_cycles(5);
        check("rst_value", 32'(value), 32'h00);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        idle_cycles(10);

        // Single good frame.
        expect_frame(8'hA5, 1'b1, 1'b0);
        idle_cycles(5);

        // Glitch shorter than half a bit is a false start.
        rx = 1'b0;
        idle_cycles(4);
        rx = 1'b1;
        idle_cycles(12);
        check("false_start_busy", 32'(busy), 32'd0);
        check("false_start_valid", 32'(n_valid), 32'(exp_valid));
        check("false_start_ferr", 32'(n_ferr), 32'(exp_ferr));
        check("false_start_value", 32'(value), 32'(exp_value));

        // Low stop bit followed by a long break: exactly one frame error.
        expect_frame(8'h3C, 1'b0, 1'b0);
        idle_cycles(100);
        check("break_single_ferr", 32'(n_ferr), 32'(exp_ferr));
        check("break_busy", 32'(busy), 32'd1);
        rx = 1'b1;
        idle_cycles(20);
        check("break_recovered_busy", 32'(busy), 32'd0);
        expect_frame(8'h55, 1'b1, 1'b0);

        // Back-to-back frames with no idle gap.
        expect_frame(8'h00, 1'b1, 1'b0);
        expect_frame(8'hFF, 1'b1, 1'b0);
        idle_cycles(20);

        // Reset in the middle of bit 4 of 0x81 aborts the frame silently.
        start_cyc = cyc;
        b = 8'h81;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rx = b[4];
        idle_cycles(CPB / 2);
        rst = 1'b1;
        idle_cycles(3);
        rx = 1'b1;
        rst = 1'b0;
        exp_value = 8'h00;
        idle_cycles(10 * CPB);
        check("abort_valid", 32'(n_valid), 32'(exp_valid));
        check("abort_ferr", 32'(n_ferr), 32'(exp_ferr));
        check("abort_value", 32'(value), 32'h00);
        check("abort_busy", 32'(busy), 32'd0);
        expect_frame(8'h42, 1'b1, 1'b0);
        idle_cycles(10);

`ifdef UART_RX_PARITY_EN
        // Wrong parity then correct parity for 0x07.
        expect_frame(8'h07, 1'b1, 1'b1);
        idle_cycles(5);
        expect_frame(8'h07, 1'b1, 1'b0);
        idle_cycles(5);
`endif

        // Randomized frames with random stop errors, gaps, and parity faults.
        for (int k = 0; k < 24; k++) begin
            b      = 8'($urandom);
            stop_b = ($urandom_range(0, 4) != 0);
            flip   = HAS_PAR && ($urandom_range(0, 5) == 0);
            expect_frame(b, stop_b, flip);
            if (!stop_b) begin
                idle_cycles($urandom_range(0, 40));
                rx = 1'b1;
                idle_cycles(4);
            end
            gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 30);
            if (gap > 0) idle_cycles(gap);
        end

        idle_cycles(20);
        check("final_valid_count", 32'(n_valid), 32'(exp_valid));
        check("final_ferr_count", 32'(n_ferr), 32'(exp_ferr));
        check("final_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
